calc_driver: RTL and testbench

Command-side initiator for the small calculator: it sits in front of the calculator's go/op/in1/in2 inputs and done/out outputs and drives that interface on behalf of a host. Host commands (op, two 3-bit operands) are buffered in a small FIFO, issued one at a time with a go/done handshake, and each result is returned on a valid/ready response port with a timeout flag.

---
 rtl/calc_pkg.sv | 20 ++
 rtl/calc_cmd_fifo.sv | 48 ++++
 rtl/calc_driver.sv | 151 +++++++++++++++
 tb/tb_calc_driver.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared widths, FSM states and the command entry layout for the calculator driver.
package calc_pkg;
  localparam int OP_W   = 2;
  localparam int DATA_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    RELEASE
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);
endpackage

// File: rtl/calc_cmd_fifo.sv
// Synchronous FIFO with a combinational head read; push/pop take effect at the clock edge.
// A push is dropped while full, a pop is ignored while empty, and push+pop together keep count.
module calc_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop,
  output logic [W-1:0]           pop_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

// File: rtl/calc_driver.sv
// Queues host commands and drives the calculator go/done handshake; response 3+ cycles after push.
// cmd_ready drops when the FIFO is full; a response is held until res_ready and blocks the next issue.
module calc_driver
  import calc_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [OP_W-1:0]   res_op,
  output logic              res_timeout,
  output logic              go,
  output logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] in1,
  output logic [DATA_W-1:0] in2,
  input  logic              done,
  input  logic [DATA_W-1:0] out,
  output logic              busy
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    go_d, res_valid_d, res_timeout_d;
  logic [OP_W-1:0]         op_d, res_op_d;
  logic [DATA_W-1:0]       in1_d, in2_d, res_data_d;
  logic [1:0]              rst_sync;
  logic                    run;
  cmd_t                    cmd_in, head;
  logic                    fifo_pop, fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0]  fifo_count;

  assign cmd_in    = '{op: cmd_op, a: cmd_a, b: cmd_b};
  assign cmd_ready = !fifo_full;
  assign busy      = (state_q != IDLE) || (fifo_count != '0);
  assign run       = rst_sync[1];

  calc_cmd_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (cmd_valid),
    .push_dat (cmd_in),
    .pop      (fifo_pop),
    .pop_dat  (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Reset assertion is immediate; release reaches the FSM two edges later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync <= '0;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    go_d          = go;
    op_d          = op;
    in1_d         = in1;
    in2_d         = in2;
    res_valid_d   = res_valid;
    res_data_d    = res_data;
    res_op_d      = res_op;
    res_timeout_d = res_timeout;
    fifo_pop      = 1'b0;
    case (state_q)
      IDLE: begin
        // A done still high from the previous operation blocks the next issue.
        if (run && !fifo_empty && !done) begin
          fifo_pop = 1'b1;
          op_d     = head.op;
          in1_d    = head.a;
          in2_d    = head.b;
          go_d     = 1'b1;
          cnt_d    = '0;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (done) begin
          res_data_d    = out;
          res_op_d      = op;
          res_timeout_d = 1'b0;
          go_d          = 1'b0;
          res_valid_d   = 1'b1;
          state_d       = RESP;
        end else if (cnt_q == LAST) begin
          res_data_d    = '0;
          res_op_d      = op;
          res_timeout_d = 1'b1;
          go_d          = 1'b0;
          res_valid_d   = 1'b1;
          state_d       = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = RELEASE;
        end
      end
      RELEASE: begin
        go_d = 1'b0;
        if (!done || cnt_q == LAST) state_d = IDLE;
        else                        cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      go          <= 1'b0;
      op          <= '0;
      in1         <= '0;
      in2         <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_op      <= '0;
      res_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      go          <= go_d;
      op          <= op_d;
      in1         <= in1_d;
      in2         <= in2_d;
      res_valid   <= res_valid_d;
      res_data    <= res_data_d;
      res_op      <= res_op_d;
      res_timeout <= res_timeout_d;
    end
  end
endmodule

// File: tb/tb_calc_driver.sv
// Bench for calc_driver: a behavioural calculator model, a response scoreboard and scenario tasks.
module tb_calc_driver;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_a, cmd_b;
  logic       res_valid, res_ready, res_timeout;
  logic [2:0] res_data;
  logic [1:0] res_op;
  logic       go, done, busy;
  logic [1:0] op;
  logic [2:0] in1, in2, out;

  typedef struct {
    logic [1:0] op;
    logic [2:0] data;
    logic       to;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   calc_en, calc_rand, pushes_done;
  int   calc_lat, calc_hold;
  int   go_age = 0;
  int   hold_cnt = 0;

  calc_driver #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_op(res_op), .res_timeout(res_timeout),
    .go(go), .op(op), .in1(in1), .in2(in2),
    .done(done), .out(out), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] calc_ref(input logic [1:0] o, input logic [2:0] a, input logic [2:0] b);
    logic [2:0] r;
    case (o)
      2'd0:    r = a + b;
      2'd1:    r = a - b;
      2'd2:    r = a & b;
      default: r = a ^ b;
    endcase
    return r;
  endfunction

  // Calculator model: done rises after go has been high calc_lat cycles, drops calc_hold cycles after go falls.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (go) go_age++;
      else    go_age = 0;
      if (go && go_age == 1 && calc_rand) calc_lat = $urandom_range(1, 5);
      if (go) hold_cnt = 0;
      if (calc_en && go && go_age == calc_lat) begin
        done = 1'b1;
        out  = calc_ref(op, in1, in2);
      end else if (!go && done) begin
        if (hold_cnt >= calc_hold) done = 1'b0;
        else                       hold_cnt++;
      end
    end
  end

  // Scoreboard: every accepted response must match the oldest accepted command.
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (rst && res_valid && res_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL resp_unexpected got op=%0d data=%0d to=%0b with nothing outstanding", res_op, res_data, res_timeout);
        end else begin
          e = exp_q.pop_front();
          if ({res_op, res_data, res_timeout} !== {e.op, e.data, e.to}) begin
            n_err++;
            $display("FAIL resp_fields got op=%0d data=%0d to=%0b want op=%0d data=%0d to=%0b",
                     res_op, res_data, res_timeout, e.op, e.data, e.to);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] o, input logic [2:0] a, input logic [2:0] b,
                      input int max_wait, output int waited, output bit ready0);
    exp_t e;
    cmd_valid = 1'b1;
    cmd_op = o; cmd_a = a; cmd_b = b;
    ready0 = cmd_ready;
    waited = 0;
    while (!cmd_ready && waited < max_wait) begin
      step();
      waited++;
    end
    if (!cmd_ready) begin
      n_vec++; n_err++;
      $display("FAIL push_stall cmd_ready=0 after %0d cycles, want 1", waited);
      cmd_valid = 1'b0;
      return;
    end
    e.op   = o;
    e.data = calc_en ? calc_ref(o, a, b) : 3'd0;
    e.to   = !calc_en;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    @(negedge clk);
    while ((busy || exp_q.size() != 0) && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (busy || exp_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout busy=%0b pending=%0d want busy=0 pending=0", busy, exp_q.size());
    end
    step();
  endtask

  task automatic test_reset();
    #12;
    n_vec++;
    if ({go, res_valid, res_timeout, busy} !== 4'b0000) begin
      n_err++; $display("FAIL reset_ctrl go/valid/to/busy=%b want 0000", {go, res_valid, res_timeout, busy});
    end
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_ready cmd_ready=%b want 1", cmd_ready);
    end
    n_vec++;
    if ({op, in1, in2, res_data, res_op} !== 13'd0) begin
      n_err++; $display("FAIL reset_data op=%0d in1=%0d in2=%0d data=%0d rop=%0d want all 0", op, in1, in2, res_data, res_op);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (4) step();
  endtask

  task automatic test_single();
    int w, gc = 0, c = 0;
    bit r0;
    calc_en = 1; calc_lat = 3; calc_hold = 0; res_ready = 1'b1;
    push(2'd0, 3'd3, 3'd2, 10, w, r0);
    forever begin
      @(negedge clk);
      if (res_valid || c > 20) break;
      if (go) gc++;
      c++;
    end
    n_vec++;
    if (gc !== 3) begin n_err++; $display("FAIL single_go_len go high %0d cycles want 3", gc); end
    n_vec++;
    if ({res_valid, res_data, res_op, res_timeout, go} !== {1'b1, 3'd5, 2'd0, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL single_resp valid=%b data=%0d op=%0d to=%b go=%b want 1 5 0 0 0", res_valid, res_data, res_op, res_timeout, go);
    end
    @(negedge clk);
    n_vec++;
    if ({busy, res_valid} !== 2'b10) begin n_err++; $display("FAIL single_release busy/valid=%b want 10", {busy, res_valid}); end
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle busy=%b want 0", busy); end
    step();
  endtask

  task automatic test_timeout();
    int w, k = 0, c = 0;
    bit r0;
    calc_en = 0; res_ready = 1'b1;
    push(2'd1, 3'd5, 3'd6, 10, w, r0);
    do begin @(negedge clk); c++; end while (!go && c < 10);
    do begin @(negedge clk); k++; end while (!res_valid && k < 200);
    n_vec++;
    if (k !== TIMEOUT) begin n_err++; $display("FAIL timeout_latency res_valid %0d cycles after go want %0d", k, TIMEOUT); end
    n_vec++;
    if ({res_timeout, res_data, res_op, go} !== {1'b1, 3'd0, 2'd1, 1'b0}) begin
      n_err++; $display("FAIL timeout_resp to=%b data=%0d op=%0d go=%b want 1 0 1 0", res_timeout, res_data, res_op, go);
    end
    wait_idle(100);
  endtask

  task automatic test_fill();
    int w;
    bit r0;
    calc_en = 0; res_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 200, w, r0);
      n_vec++;
      if (r0 !== (i < 5)) begin n_err++; $display("FAIL fill_ready push %0d cmd_ready=%b want %b", i, r0, i < 5); end
      if (i == 5) begin
        n_vec++;
        if (w !== TIMEOUT) begin n_err++; $display("FAIL fill_stall 6th push waited %0d cycles want %0d", w, TIMEOUT); end
      end
    end
    wait_idle(1000);
  endtask

  task automatic test_backpressure();
    int w, c = 0;
    bit r0;
    exp_t e;
    calc_en = 1; calc_lat = 2; calc_hold = 0; res_ready = 1'b0;
    push(2'd2, 3'd6, 3'd3, 10, w, r0);
    push(2'd3, 3'd5, 3'd1, 10, w, r0);
    do begin @(negedge clk); c++; end while (!res_valid && c < 20);
    e = exp_q[0];
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_vec++;
      if ({res_valid, go, res_op, res_data, res_timeout} !== {1'b1, 1'b0, e.op, e.data, e.to}) begin
        n_err++; $display("FAIL hold_stable cyc %0d valid=%b go=%b op=%0d data=%0d to=%b want 1 0 %0d %0d %b",
                          i, res_valid, go, res_op, res_data, res_timeout, e.op, e.data, e.to);
      end
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(posedge clk);
    c = 0;
    do begin @(negedge clk); c++; end while (!go && c < 10);
    n_vec++;
    if (c !== 3) begin n_err++; $display("FAIL hold_next_go go rose %0d cycles after accept want 3", c); end
    wait_idle(50);
  endtask

  task automatic test_done_hold();
    int w, idx = 0, d_idx = -1, g_idx = -1, overlap = 0, c = 0;
    bit r0;
    calc_en = 1; calc_lat = 2; calc_hold = 6; res_ready = 1'b1;
    push(2'd0, 3'd7, 3'd7, 10, w, r0);
    push(2'd1, 3'd2, 3'd4, 10, w, r0);
    do begin @(negedge clk); c++; end while (!res_valid && c < 20);
    while (idx < 40) begin
      @(negedge clk);
      idx++;
      if (!done && d_idx < 0) d_idx = idx;
      if (go) begin
        if (done) overlap++;
        g_idx = idx;
        break;
      end
    end
    n_vec++;
    if (overlap !== 0) begin n_err++; $display("FAIL done_hold_overlap go issued while done high count=%0d want 0", overlap); end
    n_vec++;
    if (g_idx - d_idx !== 2) begin n_err++; $display("FAIL done_hold_gap go %0d cycles after done fell want 2", g_idx - d_idx); end
    wait_idle(60);
    calc_hold = 0;
  endtask

  task automatic test_reset_mid();
    int w, k = 0, gc = 0, c = 0;
    bit r0;
    calc_en = 0; res_ready = 1'b1;
    for (int i = 0; i < 3; i++) push(2'(i), 3'(i + 1), 3'(i + 2), 10, w, r0);
    do begin @(negedge clk); c++; end while (!go && c < 10);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++;
    if ({go, res_valid, cmd_ready, busy} !== 4'b0010) begin
      n_err++; $display("FAIL async_reset go/valid/ready/busy=%b want 0010", {go, res_valid, cmd_ready, busy});
    end
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (4) step();
    calc_en = 1; calc_lat = 1;
    push(2'd3, 3'd6, 3'd5, 10, w, r0);
    do begin
      @(negedge clk); k++;
      if (!res_valid && go) gc++;
    end while (!res_valid && k < 20);
    n_vec++;
    if ({k, gc} !== {32'd3, 32'd1}) begin
      n_err++; $display("FAIL min_latency res_valid after %0d cycles go %0d cycles want 3 and 1", k, gc);
    end
    wait_idle(30);
  endtask

  task automatic test_random();
    calc_en = 1; calc_rand = 1; calc_hold = $urandom_range(0, 2);
    pushes_done = 0;
    fork
      begin
        int w;
        bit r0;
        for (int i = 0; i < 24; i++) begin
          repeat ($urandom_range(0, 2)) step();
          push(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 500, w, r0);
        end
        pushes_done = 1;
      end
      begin
        for (int c = 0; c < 4000 && !(pushes_done && exp_q.size() == 0 && !busy); c++) begin
          res_ready = 1'($urandom_range(0, 1));
          step();
        end
        res_ready = 1'b1;
      end
    join
    n_vec++;
    if (exp_q.size() !== 0 || busy !== 1'b0) begin
      n_err++; $display("FAIL random_drain pending=%0d busy=%b want 0 0", exp_q.size(), busy);
    end
    calc_rand = 0;
  endtask

  initial begin
    rst = 1'b0;
    cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    res_ready = 1'b0; done = 1'b0; out = '0;
    calc_en = 1; calc_rand = 0; calc_lat = 3; calc_hold = 0; pushes_done = 0;
    test_reset();
    test_single();
    test_timeout();
    test_fill();
    test_backpressure();
    test_done_hold();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
